// File: rtl/memoria_sync.sv
// Single-port synchronous RAM with self-clearing after reset or on request,
// read-valid strobe, out-of-range detection and optional output register.
module memoria_sync #(
  parameter int DATA_W  = 14,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 32,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              in_range, acc, rd_acc, rd_err, wr_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic              p1_v, p1_err, werr_q;
  logic [DATA_W-1:0] p1_data;

  assign in_range = {1'b0, address} < DEPTH_X;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy      = 1'b0;
    acc       = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = address;
    mem_wdata = datain;
    case (state_q)
      CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        // clr wins over any access presented in the same cycle
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          acc    = en && rst_n;
          mem_we = acc && wr && in_range;
        end
      end
      default: state_d = CLEAR;
    endcase
    rd_acc = acc && !wr;
    rd_err = rd_acc && !in_range;
    wr_err = acc && wr && !in_range;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      p1_v    <= 1'b0;
      p1_err  <= 1'b0;
      werr_q  <= 1'b0;
      p1_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p1_v    <= rd_acc;
      p1_err  <= rd_err;
      werr_q  <= wr_err;
      if (rd_acc) p1_data <= in_range ? mem[address] : '0;
    end
  end

  generate
    if (OUT_REG == 0) begin : g_direct
      assign dataout  = p1_data;
      assign rd_valid = p1_v;
      assign addr_err = p1_err | werr_q;
    end else begin : g_outreg
      logic              p2_v, p2_err;
      logic [DATA_W-1:0] p2_data;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          p2_v    <= 1'b0;
          p2_err  <= 1'b0;
          p2_data <= '0;
        end else begin
          p2_v   <= p1_v;
          p2_err <= p1_err;
          if (p1_v) p2_data <= p1_data;
        end
      end

      // write errors keep their one-cycle timing; read errors follow rd_valid
      assign dataout  = p2_data;
      assign rd_valid = p2_v;
      assign addr_err = p2_err | werr_q;
    end
  endgenerate

endmodule
